// File: rtl/watch_cmd_arbiter.sv
// ============================================================================
// Module      : watch_cmd_arbiter
// Description : Watch setting FSM that merges button edges and UART commands.
//               Auto-repeat of held inc/dec buttons when WATCH_AUTO_REPEAT_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module watch_cmd_arbiter #(
    parameter int unsigned REPEAT_DLY  = 50_000_000,
    parameter int unsigned REPEAT_RATE = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_clear,
    input  logic       btn_move,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       tx_empty,
    output logic [1:0] digit_mode,
    output logic       inc,
    output logic       dec,
    output logic       clear,
    output logic [3:0] state_led,
    output logic       cmd_drop
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_SEC  = 2'd1,
        S_MIN  = 2'd2,
        S_HOUR = 2'd3
    } state_t;

    localparam logic [1:0] c_CMD_CLR  = 2'd0;
    localparam logic [1:0] c_CMD_MOVE = 2'd1;
    localparam logic [1:0] c_CMD_INC  = 2'd2;
    localparam logic [1:0] c_CMD_DEC  = 2'd3;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_armed;
    logic [3:0] r_btn_prev;
    logic [3:0] w_btn;
    logic [3:0] w_ev;
    logic       w_btn_any;
    logic       w_in_set;
    logic       r_pend_valid;
    logic [1:0] r_pend_cmd;
    logic       w_rx_hit;
    logic [1:0] w_rx_cmd;
    logic       w_exec;
    logic       w_do_clear;
    logic       w_do_move;
    logic       w_do_inc;
    logic       w_do_dec;
    logic       w_rpt_fire;
    logic       w_rpt_is_inc;

    // Bit order {dec, inc, move, clear}; events are suppressed for the first
    // edge after reset so a button held through reset needs a fresh press.
    assign w_btn     = {btn_dec, btn_inc, btn_move, btn_clear};
    assign w_ev      = w_btn & ~r_btn_prev & {4{r_armed}};
    assign w_btn_any = (|w_ev) | w_rpt_fire;
    assign w_in_set  = (r_state != S_RUN);
    assign w_exec    = r_pend_valid & tx_empty & ~w_btn_any;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed    <= 1'b0;
            r_btn_prev <= 4'b0000;
        end else begin
            r_armed    <= 1'b1;
            r_btn_prev <= w_btn;
        end
    end

    always_comb begin
        w_rx_hit = 1'b0;
        w_rx_cmd = c_CMD_CLR;
        if (rx_valid) begin
            case (rx_data)
                8'h43, 8'h63: begin w_rx_hit = 1'b1; w_rx_cmd = c_CMD_CLR;  end
                8'h4D, 8'h6D: begin w_rx_hit = 1'b1; w_rx_cmd = c_CMD_MOVE; end
                8'h55, 8'h75: begin w_rx_hit = 1'b1; w_rx_cmd = c_CMD_INC;  end
                8'h44, 8'h64: begin w_rx_hit = 1'b1; w_rx_cmd = c_CMD_DEC;  end
                default:      begin w_rx_hit = 1'b0; w_rx_cmd = c_CMD_CLR;  end
            endcase
        end
    end

    // A fresh decode always wins the slot; an executing command frees it first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_valid <= 1'b0;
            r_pend_cmd   <= c_CMD_CLR;
        end else if (w_rx_hit) begin
            r_pend_valid <= 1'b1;
            r_pend_cmd   <= w_rx_cmd;
        end else if (w_exec) begin
            r_pend_valid <= 1'b0;
        end
    end

    // Single winner per cycle: button events, then auto-repeat, then UART.
    always_comb begin
        w_do_clear = 1'b0;
        w_do_move  = 1'b0;
        w_do_inc   = 1'b0;
        w_do_dec   = 1'b0;
        if (w_ev[0]) begin
            w_do_clear = 1'b1;
        end else if (w_ev[1]) begin
            w_do_move = 1'b1;
        end else if (w_ev[2]) begin
            w_do_inc = 1'b1;
        end else if (w_ev[3]) begin
            w_do_dec = 1'b1;
        end else if (w_rpt_fire) begin
            w_do_inc = w_rpt_is_inc;
            w_do_dec = ~w_rpt_is_inc;
        end else if (w_exec) begin
            case (r_pend_cmd)
                c_CMD_CLR:  w_do_clear = 1'b1;
                c_CMD_MOVE: w_do_move  = 1'b1;
                c_CMD_INC:  w_do_inc   = 1'b1;
                default:    w_do_dec   = 1'b1;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_do_clear) begin
            w_state_nxt = S_RUN;
        end else if (w_do_move) begin
            case (r_state)
                S_RUN:   w_state_nxt = S_SEC;
                S_SEC:   w_state_nxt = S_MIN;
                S_MIN:   w_state_nxt = S_HOUR;
                default: w_state_nxt = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_mode <= 2'd0;
            state_led  <= 4'b0001;
            inc        <= 1'b0;
            dec        <= 1'b0;
            clear      <= 1'b0;
            cmd_drop   <= 1'b0;
        end else begin
            digit_mode <= w_state_nxt;
            state_led  <= 4'b0001 << w_state_nxt;
            inc        <= w_do_inc & w_in_set;
            dec        <= w_do_dec & w_in_set;
            clear      <= w_do_clear;
            cmd_drop   <= w_rx_hit & r_pend_valid & ~w_exec;
        end
    end

`ifdef WATCH_AUTO_REPEAT_EN
    localparam int unsigned c_CNT_W = $clog2(REPEAT_DLY + REPEAT_RATE + 1);
    localparam logic [c_CNT_W-1:0] c_RPT_FIRST = c_CNT_W'(REPEAT_DLY);
    localparam logic [c_CNT_W-1:0] c_RPT_NEXT  = c_CNT_W'(REPEAT_DLY + REPEAT_RATE);

    logic               r_rpt_active;
    logic               r_rpt_is_inc;
    logic [c_CNT_W-1:0] r_rpt_cnt;
    logic [c_CNT_W-1:0] w_rpt_cnt_inc;
    logic               w_rpt_held;

    assign w_rpt_is_inc  = r_rpt_is_inc;
    assign w_rpt_held    = r_rpt_is_inc ? btn_inc : btn_dec;
    assign w_rpt_cnt_inc = r_rpt_cnt + c_CNT_W'(1);
    assign w_rpt_fire    = r_rpt_active & w_rpt_held & w_in_set &
                           ((w_rpt_cnt_inc == c_RPT_FIRST) || (w_rpt_cnt_inc == c_RPT_NEXT));

    // Counter holds cycles since the press; it folds back to the first-repeat
    // point after each later repeat so it never exceeds DLY+RATE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rpt_active <= 1'b0;
            r_rpt_is_inc <= 1'b0;
            r_rpt_cnt    <= '0;
        end else if (!w_in_set || w_do_clear || w_do_move) begin
            r_rpt_active <= 1'b0;
            r_rpt_cnt    <= '0;
        end else if (w_ev[2] || w_ev[3]) begin
            r_rpt_active <= 1'b1;
            r_rpt_is_inc <= w_ev[2];
            r_rpt_cnt    <= '0;
        end else if (r_rpt_active && w_rpt_held) begin
            r_rpt_cnt <= (w_rpt_cnt_inc == c_RPT_NEXT) ? c_RPT_FIRST : w_rpt_cnt_inc;
        end else begin
            r_rpt_active <= 1'b0;
            r_rpt_cnt    <= '0;
        end
    end
`else
    assign w_rpt_fire   = 1'b0;
    assign w_rpt_is_inc = 1'b0;

    if (REPEAT_DLY == 0 || REPEAT_RATE == 0) begin : g_rpt_cfg_zero
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_watch_cmd_arbiter.sv
// ============================================================================
// Module      : tb_watch_cmd_arbiter
// Description : Directed self-checking bench for watch_cmd_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_watch_cmd_arbiter;

`ifdef WATCH_AUTO_REPEAT_EN
    localparam bit c_RPT = 1'b1;
`else
    localparam bit c_RPT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_clear = 1'b0;
    logic       btn_move  = 1'b0;
    logic       btn_inc   = 1'b0;
    logic       btn_dec   = 1'b0;
    logic [7:0] rx_data   = 8'h00;
    logic       rx_valid  = 1'b0;
    logic       tx_empty  = 1'b0;
    logic [1:0] digit_mode;
    logic       inc;
    logic       dec;
    logic       clear;
    logic [3:0] state_led;
    logic       cmd_drop;

    int n_tests = 0;
    int n_fail  = 0;

    watch_cmd_arbiter #(
        .REPEAT_DLY  (20),
        .REPEAT_RATE (5)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .btn_clear  (btn_clear),
        .btn_move   (btn_move),
        .btn_inc    (btn_inc),
        .btn_dec    (btn_dec),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_empty   (tx_empty),
        .digit_mode (digit_mode),
        .inc        (inc),
        .dec        (dec),
        .clear      (clear),
        .state_led  (state_led),
        .cmd_drop   (cmd_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    initial begin
        int n_dec;
        logic exp_dec;

        // Reset state
        tick();
        tick();
        check("rst_mode", digit_mode, 2'd0);
        check("rst_led", state_led, 4'b0001);
        check("rst_pulses", {inc, dec, clear, cmd_drop}, 4'b0000);
        rst = 1'b0;
        tick();
        tick();
        check("post_rst_pulses", {inc, dec, clear, cmd_drop}, 4'b0000);

        // Move cycles through the states and wraps to RUN
        for (int i = 1; i <= 4; i++) begin
            btn_move = 1'b1;
            tick();
            check("move_mode", digit_mode, 32'(i % 4));
            check("move_led", state_led, 32'(4'b0001 << (i % 4)));
            btn_move = 1'b0;
            tick();
        end

        // Inc in RUN is ignored
        btn_inc = 1'b1;
        tick();
        check("run_inc_ignored", {inc, dec, clear}, 3'b000);
        btn_inc = 1'b0;
        tick();

        // Inc in SET_MIN: one pulse, one cycle wide
        for (int i = 0; i < 2; i++) begin
            btn_move = 1'b1; tick();
            btn_move = 1'b0; tick();
        end
        check("to_min", digit_mode, 2'd2);
        btn_inc = 1'b1;
        tick();
        check("min_inc_pulse", {inc, dec, clear}, 3'b100);
        tick();
        check("min_inc_width", {inc, dec, clear}, 3'b000);
        btn_inc = 1'b0;
        tick();

        // Clear beats inc in the same cycle
        btn_clear = 1'b1; tick();
        check("clear_from_min", {clear, 2'(digit_mode)}, 3'b100);
        btn_clear = 1'b0; tick();
        btn_move = 1'b1; tick();
        btn_move = 1'b0; tick();
        check("to_sec", digit_mode, 2'd1);
        btn_clear = 1'b1;
        btn_inc   = 1'b1;
        tick();
        check("clr_inc_pulses", {inc, dec, clear}, 3'b001);
        check("clr_inc_mode", digit_mode, 2'd0);
        btn_clear = 1'b0;
        btn_inc   = 1'b0;
        tick();
        check("clr_one_cycle", clear, 1'b0);

        // UART overwrite with TX busy, then pending inc runs in RUN
        rx_byte(8'h4D);
        check("drop_first", cmd_drop, 1'b0);
        rx_byte(8'h55);
        check("drop_second", cmd_drop, 1'b1);
        tick();
        check("drop_one_cycle", cmd_drop, 1'b0);
        tx_empty = 1'b1;
        tick();
        check("uart_inc_in_run", {inc, dec, clear, 2'(digit_mode)}, 5'b00000);
        tick();
        check("uart_pend_empty", {inc, dec, clear, 2'(digit_mode)}, 5'b00000);

        // 'm' executes as 'u' arrives: no drop, then one inc in SET_SEC
        rx_byte(8'h6D);
        rx_byte(8'h75);
        check("exec_and_new_mode", digit_mode, 2'd1);
        check("exec_and_new_nodrop", cmd_drop, 1'b0);
        tick();
        check("uart_inc_pulse", {inc, dec, clear}, 3'b100);
        tick();
        check("uart_inc_width", {inc, dec, clear}, 3'b000);

        // Unknown byte has no effect
        rx_byte(8'h41);
        tick();
        check("bad_byte", {inc, dec, clear, cmd_drop, 2'(digit_mode)}, 6'b000001);

        // Button event delays a pending UART dec by one cycle
        tx_empty = 1'b0;
        rx_byte(8'h44);
        tx_empty = 1'b1;
        btn_move = 1'b1;
        tick();
        check("btn_over_uart_mode", digit_mode, 2'd2);
        check("btn_over_uart_dec", dec, 1'b0);
        btn_move = 1'b0;
        tick();
        check("uart_dec_after_btn", {inc, dec, clear}, 3'b010);
        tick();

        // Held dec in SET_HOUR
        btn_move = 1'b1; tick();
        btn_move = 1'b0; tick();
        check("to_hour", digit_mode, 2'd3);
        btn_dec = 1'b1;
        n_dec = 0;
        for (int n = 0; n <= 30; n++) begin
            tick();
            exp_dec = (n == 0) || (c_RPT && (n == 20 || n == 25 || n == 30));
            if (dec) n_dec++;
            check($sformatf("hold_dec_%0d", n), dec, exp_dec);
        end
        check("hold_dec_total", n_dec, c_RPT ? 4 : 1);
        btn_dec = 1'b0;
        tick();
        check("hold_dec_release", dec, 1'b0);

        // Reset mid-operation with a pending clear and inc held through reset
        tx_empty = 1'b0;
        rx_byte(8'h43);
        tick();
        check("pend_before_rst", digit_mode, 2'd3);
        rst     = 1'b1;
        btn_inc = 1'b1;
        tick();
        check("mid_rst_mode", digit_mode, 2'd0);
        check("mid_rst_led", state_led, 4'b0001);
        rst = 1'b0;
        tick();
        check("rst_release_pulses", {inc, dec, clear, cmd_drop}, 4'b0000);
        tx_empty = 1'b1;
        tick();
        tick();
        check("no_pend_after_rst", {inc, dec, clear, 2'(digit_mode)}, 5'b00000);

        // Held-through-reset inc stays silent until re-pressed
        btn_move = 1'b1; tick();
        check("held_move_mode", digit_mode, 2'd1);
        check("held_no_inc", inc, 1'b0);
        btn_move = 1'b0; tick(); tick();
        check("held_still_no_inc", inc, 1'b0);
        btn_inc = 1'b0; tick();
        btn_inc = 1'b1; tick();
        check("repress_inc", {inc, dec, clear}, 3'b100);
        btn_inc = 1'b0; tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
